// File: rtl/pi_est_pkg.sv
// Shared types and constants for the pi estimator sample engine: FSM states,
// Galois LFSR tap masks per width and per-lane seed derivation.
package pi_est_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] SEED_STEP = 32'h1357;

    // Right-shifting Galois masks for maximal-length polynomials.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return 32'h0000_00B8;
            10:      return 32'h0000_0240;
            12:      return 32'h0000_0829;
            14:      return 32'h0000_2015;
            16:      return 32'h0000_D008;
            18:      return 32'h0002_0400;
            20:      return 32'h0009_0000;
            22:      return 32'h0030_0000;
            24:      return 32'h00E1_0000;
            default: return 32'd3 << (w - 2);
        endcase
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [63:0] lane_seed(input logic [31:0] base, input int lane, input int w);
        logic [63:0] s;
        s = {32'd0, base ^ (SEED_STEP * 32'(lane))} & ((64'd1 << w) - 64'd1);
        if (s == 64'd0) s = 64'd1;
        return s;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR lane with synchronous reseed (load has priority over enable).
module lfsr_galois
    import pi_est_pkg::*;
#(
    parameter int          W    = 18,
    parameter logic [W-1:0] SEED = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_load,
    output logic [W-1:0] o_q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] r_q;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_q <= SEED;
        else if (i_load) r_q <= SEED;
        else if (i_en)   r_q <= {1'b0, r_q[W-1:1]} ^ (r_q[0] ? TAPS : '0);
    end

    assign o_q = r_q;

endmodule

// File: rtl/pi_sample_engine.sv
// Multi-lane Monte-Carlo point source: LFSR lanes -> classify -> counters and
// a per-lane buffer streamed out over valid/ready, under run/stop/step/clear control.
module pi_sample_engine
    import pi_est_pkg::*;
#(
    parameter int          COORD_W   = 9,
    parameter int          LANES     = 2,
    parameter int          RADIUS    = 480,
    parameter int          DIV_W     = 16,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] SEED_BASE = 32'hAACC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               clear,
    input  logic [1:0]         rate_sel,
    input  logic [CNT_W-1:0]   sample_limit,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic               pt_inside,
    output logic [CNT_W-1:0]   total_cnt,
    output logic [CNT_W-1:0]   inside_cnt,
    output logic [15:0]        overrun_cnt,
    output logic               busy,
    output logic               done
);

    localparam int                 LW   = 2 * COORD_W;
    localparam int                 DW   = 2 * COORD_W + 1;
    localparam logic [COORD_W-1:0] R_C  = COORD_W'(RADIUS);
    localparam logic [DW-1:0]      R_SQ = DW'(RADIUS * RADIUS);

    function automatic logic [DW-1:0] sq(input logic [COORD_W-1:0] v);
        logic [DW-1:0] e;
        e = DW'(v);
        return e * e;
    endfunction

    state_t                          r_state, w_state_next;
    logic                            r_final, w_go_run;
    logic [DIV_W-1:0]                r_div, w_div_mask;
    logic                            w_tick, w_empty, w_accept, w_drop;
    logic [LANES-1:0][LW-1:0]        w_q;
    logic                            r_p1, r_p2;
    logic [LANES-1:0]                w_cls_sq, w_cls_in, r_cls_sq, r_cls_in;
    logic [LANES-1:0][COORD_W-1:0]   r_cls_x, r_cls_y, r_buf_x, r_buf_y;
    logic [LANES-1:0]                r_buf_in, r_buf_vld, w_take, w_pop_mask;
    logic [CNT_W-1:0]                r_total, r_inside, w_n, w_n_in, w_total_next;
    logic                            w_budget_hit;
    logic [15:0]                     r_overrun;

    assign w_div_mask = {DIV_W{1'b1}} >> {rate_sel, 1'b0};
    assign w_tick     = ((r_state == RUN) && ((r_div & w_div_mask) == w_div_mask)) ||
                        ((r_state == IDLE) && step);
    assign w_empty    = !r_p1 && !r_p2 && (r_buf_vld == '0);
    assign w_accept   = w_tick && w_empty;
    assign w_drop     = w_tick && !w_empty;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lfsr_galois #(
            .W    (LW),
            .SEED (LW'(lane_seed(SEED_BASE, k, LW)))
        ) u_lfsr (
            .clk    (clk),
            .reset  (reset),
            .i_en   (w_accept),
            .i_load (clear),
            .o_q    (w_q[k])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_cls_sq = '0;
        w_cls_in = '0;
        for (int k = 0; k < LANES; k++) begin
            w_cls_sq[k] = (w_q[k][LW-1:COORD_W] <= R_C) && (w_q[k][COORD_W-1:0] <= R_C);
            w_cls_in[k] = (sq(w_q[k][LW-1:COORD_W]) + sq(w_q[k][COORD_W-1:0])) <= R_SQ;
        end
    end

    // Lanes are admitted in ascending order until the budget is exhausted.
    always_comb begin
        w_take = '0;
        w_n    = '0;
        w_n_in = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_p2 && r_cls_sq[k] &&
                ((sample_limit == '0) || ((r_total + w_n) < sample_limit))) begin
                w_take[k] = 1'b1;
                w_n       = w_n + CNT_W'(1);
                if (r_cls_in[k]) w_n_in = w_n_in + CNT_W'(1);
            end
        end
        w_total_next = r_total + w_n;
        w_budget_hit = (sample_limit != '0) && (w_total_next >= sample_limit);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_budget_hit || stop) w_state_next = DRAIN;
            DRAIN:   if (w_empty) w_state_next = r_final ? DONE : IDLE;
            DONE:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
        w_go_run = (w_state_next == RUN) && (r_state != RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            r_state <= IDLE;
            r_final <= 1'b0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_go_run)
                r_final <= 1'b0;
            else if (((r_state == RUN) || (r_state == DRAIN)) && w_budget_hit)
                r_final <= 1'b1;
            if (w_go_run)             r_div <= '0;
            else if (r_state == RUN)  r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            r_p1      <= 1'b0;
            r_p2      <= 1'b0;
            r_buf_vld <= '0;
        end else begin
            r_p1 <= w_accept;
            r_p2 <= r_p1;
            if (r_p2)                      r_buf_vld <= w_take;
            else if (pt_valid && pt_ready) r_buf_vld <= r_buf_vld & ~w_pop_mask;
        end
    end

    // NOTE: payload storage has no reset; it is only observable through the reset valid bits.
    always_ff @(posedge clk) begin
        if (r_p1) begin
            r_cls_sq <= w_cls_sq;
            r_cls_in <= w_cls_in;
            for (int k = 0; k < LANES; k++) begin
                r_cls_x[k] <= w_q[k][LW-1:COORD_W];
                r_cls_y[k] <= w_q[k][COORD_W-1:0];
            end
        end
        if (r_p2) begin
            r_buf_x  <= r_cls_x;
            r_buf_y  <= r_cls_y;
            r_buf_in <= r_cls_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            r_total   <= '0;
            r_inside  <= '0;
            r_overrun <= '0;
        end else if (w_go_run && (r_state == DONE)) begin
            r_total   <= '0;
            r_inside  <= '0;
            r_overrun <= '0;
        end else begin
            if (r_p2) begin
                r_total  <= w_total_next;
                r_inside <= r_inside + w_n_in;
            end
            if (w_drop && (r_overrun != 16'hFFFF)) r_overrun <= r_overrun + 16'd1;
        end
    end

    // Lowest valid lane is presented; iterating downward lets it win.
    always_comb begin
        pt_x       = '0;
        pt_y       = '0;
        pt_inside  = 1'b0;
        w_pop_mask = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (r_buf_vld[k]) begin
                pt_x          = r_buf_x[k];
                pt_y          = r_buf_y[k];
                pt_inside     = r_buf_in[k];
                w_pop_mask    = '0;
                w_pop_mask[k] = 1'b1;
            end
        end
    end

    assign pt_valid    = |r_buf_vld;
    assign total_cnt   = r_total;
    assign inside_cnt  = r_inside;
    assign overrun_cnt = r_overrun;
    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);

endmodule
